bf2ii_4bundle: RTL and testbench
================================

Name: bf2ii_4bundle

Overview:
Second radix-2^2 butterfly stage of the 16-lane parallel FFT front end. It sits directly downstream of the BF2I bundle stage and consumes its WIDTH+1 outputs. It applies the trivial -j rotation to the fourth quarter of each 4*OFFSET lane group, then performs span-OFFSET butterflies. It also tracks bundle position within a frame for the downstream twiddle stage.

Parameters:
WIDTH, 10, input sample width (equals BF2I output width).
DEPTH, 16, lanes per bundle.
OFFSET, 2, butterfly span in lanes.
NUM_BUNDLE, 32, bundles per FFT frame (512-point frame).
IDX_W, $clog2(NUM_BUNDLE), bundle index width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sync_clr  in  1  synchronous frame resync; next accepted bundle gets index 0
din_valid  in  1  input bundle valid (no backpressure)
din_R[DEPTH]  in  WIDTH signed  real inputs
din_Q[DEPTH]  in  WIDTH signed  imaginary inputs
dout_valid  out  1  output bundle valid
dout_R[DEPTH]  out  WIDTH+1 signed  real outputs
dout_Q[DEPTH]  out  WIDTH+1 signed  imaginary outputs
dout_bundle_idx  out  IDX_W  bundle index of the current output bundle
dout_frame_start  out  1  high with dout_valid when index == 0
dout_frame_end  out  1  high with dout_valid when index == NUM_BUNDLE-1

Behaviour:
- Reset (async, rst_n=0): all outputs, pipeline registers, valid bits and the bundle counter are cleared to 0. Bundles in flight are discarded; nothing emerges after release.
- Pipeline is 2 stages, fixed latency 2. A bundle accepted on edge k appears on outputs after edge k+2.
- Stage 1 (rotate): loads only when din_valid=1. Each lane is sign-extended to WIDTH+1.
  - Rotated lanes are those with (i mod 4*OFFSET) >= 3*OFFSET, i.e. lanes 6,7,14,15 at defaults.
  - A rotated lane becomes (R',Q') = (Q, -R). Negation is done at WIDTH+1, so -(-512) = 512 with no overflow.
  - The bundle index is captured alongside the data.
- Stage 2 (butterfly): loads only when the stage-1 valid bit = 1. For each group of 2*OFFSET lanes and j in 0..OFFSET-1, with a = lane g+j and b = lane g+j+OFFSET:
  - out[g+j] = a + b
  - out[g+j+OFFSET] = a - b
  - R and Q are handled independently. The result is truncated to WIDTH+1, which is lossless because the range is [-1024, 1023].
- Valid bits shift every cycle. When dout_valid=0, data, index and flag outputs hold their last values. dout_frame_start and dout_frame_end are forced to 0 whenever dout_valid=0.
- Bundle counter:
  - Increments on each accepted bundle and wraps from NUM_BUNDLE-1 to 0.
  - With sync_clr=1 and din_valid=1 in the same cycle, the accepted bundle is tagged 0 and the counter becomes 1.
  - With sync_clr=1 and din_valid=0, the counter becomes 0.
- Input gaps (din_valid=0) are allowed between any bundles. They do not advance the counter and do not corrupt in-flight data.

Decomposition:
- Shared fft_pkg holds:
  - lane count constant NUM_LANE=16
  - sample width constants (BF2I_IN_W=9, BF2II_IN_W=10)
  - frame bundle count
  - function is_rot_lane(i, offset)
  - typedef of the signed sample pair {R,Q}
- One sub-module, bf2ii_pair: registered add/sub of one lane pair with load enable. It is instantiated DEPTH/2 times via generate. Rotation and the counter stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 with inputs driven -> all dout_* = 0, dout_valid=0, index 0. After release, with no din_valid, outputs remain 0.
2. Single bundle, din_R[i]=i+1, din_Q[i]=-(i+1), valid for 1 cycle. Two edges later dout_valid=1 for exactly 1 cycle, with:
   - dout[0]=(4,-4), dout[2]=(-2,2)
   - dout[4]=(-2,-12), dout[6]=(12,2)
   - index 0, frame_start=1
3. Extremes:
   - Lane4=(511,511), lane6=(-512,-512) -> dout[4]=(-1,1023), dout[6]=(1023,-1).
   - Lane0=lane2=(-512,-512) -> dout[0]=(-1024,-1024), dout[2]=(0,0).
4. Wrap: 33 back-to-back valid bundles -> indices 0..31 then 0. frame_start on outputs 1 and 33, frame_end on output 32, flags never high together.
5. Gaps and resync:
   - Valid on alternate cycles -> dout_valid alternates and data holds between bundles.
   - sync_clr with the 6th bundle -> that bundle is output with index 0, the next with index 1.
6. Mid-stream reset: assert rst_n=0 with 2 bundles in flight -> dout_valid=0 immediately. After release, no stale bundle emerges and the first new bundle carries index 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, lane helpers and sample types for the parallel FFT front end.
package fft_pkg;
    localparam int NUM_LANE      = 16;
    localparam int BF2I_IN_W     = 9;
    localparam int BF2II_IN_W    = 10;
    localparam int FRAME_BUNDLES = 32;

    // A lane in the last quarter of its 4*offset group gets the -j rotation.
    function automatic logic is_rot_lane(input int i, input int offset);
        return (i % (4 * offset)) >= (3 * offset);
    endfunction

    typedef struct packed {
        logic signed [BF2II_IN_W:0] r;
        logic signed [BF2II_IN_W:0] q;
    } sample_pair_t;
endpackage

// File: rtl/bf2ii_4bundle_if.sv
// Bundle-level stream between the BF2I stage, this stage and the twiddle stage.
interface bf2ii_4bundle_if
    import fft_pkg::*;
#(
    parameter int WIDTH = BF2II_IN_W,
    parameter int DEPTH = NUM_LANE,
    parameter int IDX_W = $clog2(FRAME_BUNDLES)
);
    logic                    sync_clr;
    logic                    din_valid;
    logic signed [WIDTH-1:0] din_R [DEPTH];
    logic signed [WIDTH-1:0] din_Q [DEPTH];
    logic                    dout_valid;
    logic signed [WIDTH:0]   dout_R [DEPTH];
    logic signed [WIDTH:0]   dout_Q [DEPTH];
    logic [IDX_W-1:0]        dout_bundle_idx;
    logic                    dout_frame_start;
    logic                    dout_frame_end;

    modport master (
        output sync_clr, din_valid, din_R, din_Q,
        input  dout_valid, dout_R, dout_Q, dout_bundle_idx, dout_frame_start, dout_frame_end
    );

    modport slave (
        input  sync_clr, din_valid, din_R, din_Q,
        output dout_valid, dout_R, dout_Q, dout_bundle_idx, dout_frame_start, dout_frame_end
    );
endinterface

// File: rtl/bf2ii_pair.sv
// Registered sum/difference of one lane pair; holds its outputs when load is low.
module bf2ii_pair #(
    parameter int W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic signed [W-1:0] a_r,
    input  logic signed [W-1:0] a_q,
    input  logic signed [W-1:0] b_r,
    input  logic signed [W-1:0] b_q,
    output logic signed [W-1:0] sum_r,
    output logic signed [W-1:0] sum_q,
    output logic signed [W-1:0] diff_r,
    output logic signed [W-1:0] diff_q
);
    // Operands come from a rotated BF2I bundle, so results fit W bits exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= '0;
            sum_q  <= '0;
            diff_r <= '0;
            diff_q <= '0;
        end else if (load) begin
            sum_r  <= a_r + b_r;
            sum_q  <= a_q + b_q;
            diff_r <= a_r - b_r;
            diff_q <= a_q - b_q;
        end
    end
endmodule

// File: rtl/bf2ii_4bundle.sv
// BF2II bundle stage: -j rotation of the last lane quarter, span-OFFSET butterflies,
// and bundle position tracking for the twiddle stage.
module bf2ii_4bundle
    import fft_pkg::*;
#(
    parameter int WIDTH      = BF2II_IN_W,
    parameter int DEPTH      = NUM_LANE,
    parameter int OFFSET     = 2,
    parameter int NUM_BUNDLE = FRAME_BUNDLES,
    parameter int IDX_W      = $clog2(NUM_BUNDLE)
) (
    input logic             clk,
    input logic             rst_n,
    bf2ii_4bundle_if.slave  bus
);
    localparam int              OW       = WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUNDLE - 1);

    logic [IDX_W-1:0]     bundle_cnt;
    logic [IDX_W-1:0]     s1_idx;
    logic [IDX_W-1:0]     out_idx;
    logic                 s1_valid;
    logic                 out_valid;
    logic signed [OW-1:0] rot_r [DEPTH];
    logic signed [OW-1:0] rot_q [DEPTH];
    logic signed [OW-1:0] s1_r  [DEPTH];
    logic signed [OW-1:0] s1_q  [DEPTH];
    logic signed [OW-1:0] bf_r  [DEPTH];
    logic signed [OW-1:0] bf_q  [DEPTH];

    // Negation happens after widening so that -(-2^(WIDTH-1)) stays representable.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rot_r[i] = OW'(bus.din_R[i]);
            rot_q[i] = OW'(bus.din_Q[i]);
            if (is_rot_lane(i, OFFSET)) begin
                rot_r[i] = OW'(bus.din_Q[i]);
                rot_q[i] = -OW'(bus.din_R[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_r     <= '{default: '0};
            s1_q     <= '{default: '0};
        end else begin
            s1_valid <= bus.din_valid;
            if (bus.din_valid) begin
                s1_r   <= rot_r;
                s1_q   <= rot_q;
                s1_idx <= bus.sync_clr ? '0 : bundle_cnt;
            end
        end
    end

    // A resync coinciding with a bundle tags that bundle 0, so the next one is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_cnt <= '0;
        end else if (bus.din_valid) begin
            if (bus.sync_clr) begin
                bundle_cnt <= IDX_W'(1);
            end else if (bundle_cnt == LAST_IDX) begin
                bundle_cnt <= '0;
            end else begin
                bundle_cnt <= bundle_cnt + 1'b1;
            end
        end else if (bus.sync_clr) begin
            bundle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_idx <= s1_idx;
            end
        end
    end

    for (genvar p = 0; p < DEPTH / 2; p++) begin : g_pair
        localparam int A = (p / OFFSET) * 2 * OFFSET + (p % OFFSET);
        localparam int B = A + OFFSET;

        bf2ii_pair #(.W(OW)) u_pair (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (s1_valid),
            .a_r    (s1_r[A]),
            .a_q    (s1_q[A]),
            .b_r    (s1_r[B]),
            .b_q    (s1_q[B]),
            .sum_r  (bf_r[A]),
            .sum_q  (bf_q[A]),
            .diff_r (bf_r[B]),
            .diff_q (bf_q[B])
        );
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bus.dout_R[i] = bf_r[i];
            bus.dout_Q[i] = bf_q[i];
        end
    end

    assign bus.dout_valid       = out_valid;
    assign bus.dout_bundle_idx  = out_idx;
    assign bus.dout_frame_start = out_valid && (out_idx == '0);
    assign bus.dout_frame_end   = out_valid && (out_idx == LAST_IDX);
endmodule

// File: tb/tb_bf2ii_4bundle.sv
// Randomized bench for bf2ii_4bundle against a bundle-level reference model,
// plus literal expectations for the directed scenarios.
module tb_bf2ii_4bundle;
    localparam int W  = 10;
    localparam int D  = 16;
    localparam int NB = 32;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    bf2ii_4bundle_if #(.WIDTH(W), .DEPTH(D), .IDX_W(IW)) bus ();

    bf2ii_4bundle #(.WIDTH(W), .DEPTH(D), .OFFSET(2), .NUM_BUNDLE(NB), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (act running, req finished)");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: act=%0d req=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: whole-bundle arithmetic, latency 2, outputs hold when idle.
    int m_cnt, p_valid, p_idx, o_valid, o_idx;
    int p_r[D], p_q[D], o_r[D], o_q[D];

    initial begin
        int cr[D], cq[D], t, bad, bad_lane;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cnt = 0; p_valid = 0; p_idx = 0; o_valid = 0; o_idx = 0;
                for (int i = 0; i < D; i++) begin
                    p_r[i] = 0; p_q[i] = 0; o_r[i] = 0; o_q[i] = 0;
                end
            end else begin
                o_valid = p_valid;
                if (p_valid != 0) begin
                    o_idx = p_idx;
                    o_r = p_r;
                    o_q = p_q;
                end
                p_valid = int'(bus.din_valid);
                if (bus.din_valid) begin
                    for (int i = 0; i < D; i++) begin
                        cr[i] = int'(bus.din_R[i]);
                        cq[i] = int'(bus.din_Q[i]);
                        if ((i % 8) >= 6) begin
                            t = cr[i]; cr[i] = cq[i]; cq[i] = -t;
                        end
                    end
                    for (int i = 0; i < D; i++) begin
                        if (((i / 2) % 2) == 0) begin
                            p_r[i] = cr[i] + cr[i+2];
                            p_q[i] = cq[i] + cq[i+2];
                        end else begin
                            p_r[i] = cr[i-2] - cr[i];
                            p_q[i] = cq[i-2] - cq[i];
                        end
                    end
                    p_idx = bus.sync_clr ? 0 : m_cnt;
                    m_cnt = bus.sync_clr ? 1 : (m_cnt + 1) % NB;
                end else if (bus.sync_clr) begin
                    m_cnt = 0;
                end
            end
            #1;
            check_int("model_valid", int'(bus.dout_valid), o_valid);
            check_int("model_idx", int'(bus.dout_bundle_idx), o_idx);
            check_int("model_fstart", int'(bus.dout_frame_start), int'(o_valid != 0 && o_idx == 0));
            check_int("model_fend", int'(bus.dout_frame_end), int'(o_valid != 0 && o_idx == NB - 1));
            check_int("flags_exclusive", int'(bus.dout_frame_start && bus.dout_frame_end), 0);
            bad = 0; bad_lane = 0;
            for (int i = 0; i < D; i++) begin
                if (bad == 0 && (int'(bus.dout_R[i]) != o_r[i] || int'(bus.dout_Q[i]) != o_q[i])) begin
                    bad = 1; bad_lane = i;
                end
            end
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL model_data lane %0d: act=(%0d,%0d) req=(%0d,%0d) at %0t", bad_lane,
                         int'(bus.dout_R[bad_lane]), int'(bus.dout_Q[bad_lane]),
                         o_r[bad_lane], o_q[bad_lane], $time);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < D; i++) begin
            bus.din_R[i] = W'(int'($urandom_range(1023)) - 512);
            bus.din_Q[i] = W'(int'($urandom_range(1023)) - 512);
        end
    endtask

    task automatic drive(input bit sync);
        rand_data();
        bus.din_valid = 1'b1;
        bus.sync_clr  = sync;
    endtask

    task automatic idle();
        rand_data();
        bus.din_valid = 1'b0;
        bus.sync_clr  = 1'b0;
    endtask

    task automatic check_lane(input string name, input int i, input int er, input int eq);
        check_int({name, "_R"}, int'(bus.dout_R[i]), er);
        check_int({name, "_Q"}, int'(bus.dout_Q[i]), eq);
    endtask

    initial begin
        // Reset held with live inputs
        drive(1'b0);
        repeat (3) begin
            nxt();
            drive(1'b0);
        end
        check_int("rst_valid", int'(bus.dout_valid), 0);
        check_int("rst_idx", int'(bus.dout_bundle_idx), 0);
        check_lane("rst_lane0", 0, 0, 0);
        check_lane("rst_lane15", 15, 0, 0);
        idle();
        rst_n = 1'b1;
        repeat (3) nxt();
        check_int("post_rst_valid", int'(bus.dout_valid), 0);
        check_lane("post_rst_lane6", 6, 0, 0);

        // Single ramp bundle
        for (int i = 0; i < D; i++) begin
            bus.din_R[i] = W'(i + 1);
            bus.din_Q[i] = W'(-(i + 1));
        end
        bus.din_valid = 1'b1;
        bus.sync_clr  = 1'b0;
        nxt(); idle();
        nxt();
        check_int("ramp_valid", int'(bus.dout_valid), 1);
        check_lane("ramp_lane0", 0, 4, -4);
        check_lane("ramp_lane2", 2, -2, 2);
        check_lane("ramp_lane4", 4, -2, -12);
        check_lane("ramp_lane6", 6, 12, 2);
        check_int("ramp_idx", int'(bus.dout_bundle_idx), 0);
        check_int("ramp_fstart", int'(bus.dout_frame_start), 1);
        nxt();
        check_int("ramp_one_cycle", int'(bus.dout_valid), 0);
        check_lane("ramp_hold_lane4", 4, -2, -12);

        // Extremes
        drive(1'b0);
        bus.din_R[0] = -10'sd512; bus.din_Q[0] = -10'sd512;
        bus.din_R[2] = -10'sd512; bus.din_Q[2] = -10'sd512;
        bus.din_R[4] = 10'sd511;  bus.din_Q[4] = 10'sd511;
        bus.din_R[6] = -10'sd512; bus.din_Q[6] = -10'sd512;
        nxt(); idle();
        nxt();
        check_lane("ext_lane4", 4, -1, 1023);
        check_lane("ext_lane6", 6, 1023, -1);
        check_lane("ext_lane0", 0, -1024, -1024);
        check_lane("ext_lane2", 2, 0, 0);
        check_int("ext_idx", int'(bus.dout_bundle_idx), 1);

        // 33 back-to-back bundles across a frame wrap
        for (int k = 0; k < 35; k++) begin
            nxt();
            if (k >= 2) begin
                check_int("wrap_valid", int'(bus.dout_valid), 1);
                check_int("wrap_idx", int'(bus.dout_bundle_idx), (k - 2) % NB);
                check_int("wrap_fstart", int'(bus.dout_frame_start), int'(((k - 2) % NB) == 0));
                check_int("wrap_fend", int'(bus.dout_frame_end), int'((k - 2) == NB - 1));
            end
            if (k < 33) drive(k == 0);
            else idle();
        end

        // Alternate-cycle bundles, resync on the 6th
        for (int k = 0; k < 22; k++) begin
            nxt();
            if (k >= 2) begin
                if ((k % 2) == 0) begin
                    check_int("gap_valid", int'(bus.dout_valid), 1);
                    check_int("gap_idx", int'(bus.dout_bundle_idx),
                              ((k - 2) / 2 < 5) ? ((k - 2) / 2 + 1) : ((k - 2) / 2 - 5));
                end else begin
                    check_int("gap_idle", int'(bus.dout_valid), 0);
                end
            end
            if (k < 20 && (k % 2) == 0) drive(k == 10);
            else idle();
        end

        // Random traffic with occasional resync
        for (int k = 0; k < 300; k++) begin
            nxt();
            if ($urandom_range(3) != 0) drive($urandom_range(40) == 0);
            else begin
                idle();
                bus.sync_clr = ($urandom_range(20) == 0);
            end
        end

        // Mid-stream reset with two bundles in flight
        nxt(); drive(1'b0);
        nxt(); drive(1'b0);
        nxt(); idle();
        rst_n = 1'b0;
        #1;
        check_int("midrst_valid", int'(bus.dout_valid), 0);
        check_int("midrst_idx", int'(bus.dout_bundle_idx), 0);
        check_lane("midrst_lane0", 0, 0, 0);
        nxt(); nxt();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nxt();
            check_int("midrst_no_stale", int'(bus.dout_valid), 0);
        end
        drive(1'b0);
        nxt(); idle();
        nxt();
        check_int("midrst_new_valid", int'(bus.dout_valid), 1);
        check_int("midrst_new_idx", int'(bus.dout_bundle_idx), 0);
        repeat (3) nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
